mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single data port of the unified Memory between two requesters:
//  m0 = core load/store path, m1 = debug/loader master (program load, memory inspect).
//  Sits between the DataPath/debug logic and Memory's addr/inputData/en/outputData port.
//  Grants one access at a time, round-robin, and returns read data after a fixed latency.
// PARAMETERS
//  ADDR_W   16  address width, matches the Memory data-port address
//  DATA_W   32  data word width
//  MEM_LAT  1   Memory read latency in cycles, from command to valid mem_rdata (legal 1..4)
// PORTS
//  clk        in   1       system clock, rising edge
//  rst_n      in   1       asynchronous active-low reset
//  mX_req     in   1       request; held with stable addr/we/wdata until mX_gnt (X=0,1)
//  mX_we      in   1       1 = write, 0 = read
//  mX_addr    in   ADDR_W  word address
//  mX_wdata   in   DATA_W  write data
//  mX_gnt     out  1       1-cycle pulse: request accepted, memory command issued this cycle
//  mX_rvalid  out  1       1-cycle pulse: mX_rdata valid (reads only)
//  mX_rdata   out  DATA_W  read data, held until the next rvalid for that port
//  mem_en     out  1       memory write enable (Memory 'en')
//  mem_addr   out  ADDR_W  memory address
//  mem_wdata  out  DATA_W  memory write data
//  mem_rdata  in   DATA_W  memory read data
//  busy       out  1       1 while a read is outstanding (state WAIT)
// BEHAVIOUR
//  - Reset: all gnt/rvalid=0, rdata=0, mem_en=0, mem_addr=0, mem_wdata=0, busy=0,
//    state=IDLE, last_gnt=1 (so m0 wins the first conflict). Reset mid-read drops the read:
//    no rvalid is ever produced for it.
//  - FSM: IDLE, WAIT.
//    IDLE: if any req, select winner combinationally; same cycle: mX_gnt=1,
//      mem_addr/mem_wdata driven from winner, mem_en=winner we. Write -> stay IDLE
//      (write completes at that clock edge). Read -> load counter=MEM_LAT-1, go WAIT.
//      No req: mem_en=0, mem_addr holds last value.
//    WAIT: no grants; busy=1; mem_addr held; counter decrements each cycle; in the cycle
//      counter==0 the owner's rvalid=1, rdata captured from mem_rdata at that edge
//      (rdata registered, visible with rvalid), return to IDLE. New grant earliest next cycle.
//  - Throughput: back-to-back writes 1/cycle; reads 1 per (MEM_LAT+1) cycles.
//  - Arbitration (round-robin): only one req -> grant it. Both req -> grant port != last_gnt.
//    last_gnt updates on every grant. No port waits more than one foreign access.
//  - Requester dropping req before gnt is allowed; no gnt is produced for it.
//  - mem_en never asserted outside a grant cycle; never two grants in one cycle.
//  - Addresses pass unchanged; no width arithmetic; ADDR_W/DATA_W must match Memory.
// CONFIGURATION
//  ARB_FIXED_PRIO_EN defined: fixed priority, m0 always wins a conflict; last_gnt unused
//    (m1 may starve while m0 requests every cycle).
//  Undefined (default): round-robin as above.
// TESTING
//  1 Reset: rst_n=0 mid-WAIT of m0 read -> all outputs 0, no m0_rvalid after release.
//  2 m0 write addr=0x0010 data=0xDEADBEEF, then m0 read 0x0010 -> gnt same cycle as req,
//    mem_en=1 one cycle; m0_rvalid MEM_LAT+1 cycles after read req, m0_rdata=0xDEADBEEF.
//  3 m0,m1 both req reads every cycle from reset -> grants m0,m1,m0,m1; busy high in WAIT.
//  4 m1 write in flight during m0 read WAIT -> m1_gnt only after m0_rvalid cycle.
//  5 MEM_LAT=3: read -> rvalid exactly 4 cycles after gnt, no grants in between.
//  6 ARB_FIXED_PRIO_EN, both req continuously for 8 accesses -> m1_gnt never asserted.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single Memory data port between core (m0) and debug/loader (m1)
// Grants one access at a time and returns read data after MEM_LAT cycles.
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   mX_req/we/addr/wdata (X=0,1)       requests, held stable until mX_gnt
//   mX_gnt                             1-cycle pulse, command issued to memory this cycle
//   mX_rvalid/rdata                    1-cycle read-valid pulse, data held until next rvalid
//   mem_en/addr/wdata, mem_rdata       Memory data port
//   busy                               read outstanding
// Build option: ARB_FIXED_PRIO_EN selects fixed priority (m0 wins); default is round-robin.
module mem_port_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;
  localparam logic [1:0] LAT_M1 = 2'(MEM_LAT - 1);
  logic [0:0]        state;
  logic [1:0]        cnt;
  logic              owner;
  logic              sel;
  logic              grant;
  logic              win_we;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
`ifndef ARB_FIXED_PRIO_EN
  logic              last_gnt;
`endif
  always_comb begin
`ifdef ARB_FIXED_PRIO_EN
    sel = !m0_req;
`else
    sel = (m0_req && m1_req) ? !last_gnt : m1_req;
`endif
    // gating with rst_n keeps every grant-derived output low while reset is held
    grant     = rst_n && (state == IDLE) && (m0_req || m1_req);
    m0_gnt    = grant && !sel;
    m1_gnt    = grant && sel;
    win_we    = sel ? m1_we : m0_we;
    mem_en    = grant && win_we;
    mem_addr  = grant ? (sel ? m1_addr : m0_addr) : addr_q;
    mem_wdata = grant ? (sel ? m1_wdata : m0_wdata) : wdata_q;
    busy      = (state == WAIT);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      owner     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
`ifndef ARB_FIXED_PRIO_EN
      last_gnt  <= 1'b1;
`endif
    end else begin
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      if (grant) begin
        addr_q  <= mem_addr;
        wdata_q <= mem_wdata;
`ifndef ARB_FIXED_PRIO_EN
        last_gnt <= sel;
`endif
        if (!win_we) begin
          state <= WAIT;
          cnt   <= LAT_M1;
          owner <= sel;
        end
      end
      if (state == WAIT) begin
        cnt <= cnt - 2'd1;
        if (cnt == 2'd0) begin
          state <= IDLE;
          if (owner) begin
            m1_rvalid <= 1'b1;
            m1_rdata  <= mem_rdata;
          end else begin
            m0_rvalid <= 1'b1;
            m0_rdata  <= mem_rdata;
          end
        end
      end
    end
  end
endmodule
